// File: rtl/regfile_scoreboard_if.sv
// Bundles the read ports, both write ports and the load scoreboard controls of the
// register file so the core and the register file share one port list.
interface regfile_scoreboard_if #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NREAD      = 2
);
    logic [NREAD*ADDR_WIDTH-1:0] raddr;
    logic [NREAD*DATA_WIDTH-1:0] rdata;
    logic [NREAD-1:0]            rbusy;

    logic                        wa_en;
    logic [ADDR_WIDTH-1:0]       wa_addr;
    logic [DATA_WIDTH-1:0]       wa_data;

    logic                        wl_en;
    logic [ADDR_WIDTH-1:0]       wl_addr;
    logic [DATA_WIDTH-1:0]       wl_data;

    logic                        sb_set;
    logic [ADDR_WIDTH-1:0]       sb_addr;

    logic [ADDR_WIDTH:0]         busy_cnt;
    logic                        sb_err;

    modport master (
        output raddr, wa_en, wa_addr, wa_data, wl_en, wl_addr, wl_data, sb_set, sb_addr,
        input  rdata, rbusy, busy_cnt, sb_err
    );

    modport slave (
        input  raddr, wa_en, wa_addr, wa_data, wl_en, wl_addr, wl_data, sb_set, sb_addr,
        output rdata, rbusy, busy_cnt, sb_err
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Multi-read register file with ALU and LSU write ports and a per-register busy
// scoreboard for outstanding loads; register 0 reads as zero and is never busy.
module regfile_scoreboard #(
    parameter int unsigned             ADDR_WIDTH = 5,
    parameter int unsigned             DATA_WIDTH = 32,
    parameter int unsigned             NREAD      = 2,
    parameter logic [DATA_WIDTH-1:0]   SP_RESET   = DATA_WIDTH'(32'h81000000),
    parameter bit                      BYPASS     = 1'b1
) (
    input logic                  clk,
    input logic                  rst,
    regfile_scoreboard_if.slave  bus
);
    localparam int unsigned NREG = 2 ** ADDR_WIDTH;
    localparam int unsigned CNTW = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] rf_q [NREG];
    logic [NREG-1:0]       busy_q, busy_d;
    logic                  sb_err_q, sb_err_d;
    logic [CNTW-1:0]       busy_cnt;

    logic                  wa_hit_nz, wl_hit_nz, sb_nz, sb_clash;

    assign wa_hit_nz = bus.wa_en && (bus.wa_addr != '0);
    assign wl_hit_nz = bus.wl_en && (bus.wl_addr != '0);
    assign sb_nz     = bus.sb_set && (bus.sb_addr != '0);
    // A load issued to a register whose previous load retires this very cycle is legal.
    assign sb_clash  = sb_nz && busy_q[bus.sb_addr] &&
                       !(bus.wl_en && (bus.wl_addr == bus.sb_addr));

    // Register storage; the LSU assignment comes last so it wins a same-register collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                rf_q[i] <= (i == 2) ? SP_RESET : '0;
            end
        end else begin
            if (wa_hit_nz) rf_q[bus.wa_addr] <= bus.wa_data;
            if (wl_hit_nz) rf_q[bus.wl_addr] <= bus.wl_data;
        end
    end

    // Scoreboard next state: retire first, then set, so a new load to the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (bus.wl_en) busy_d[bus.wl_addr] = 1'b0;
        if (sb_nz)     busy_d[bus.sb_addr] = 1'b1;
        busy_d[0] = 1'b0;
        sb_err_d  = sb_err_q | sb_clash;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= '0;
            sb_err_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            sb_err_q <= sb_err_d;
        end
    end

    always_comb begin
        busy_cnt = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            busy_cnt = busy_cnt + CNTW'(busy_q[i]);
        end
    end

    logic [DATA_WIDTH-1:0] rd_port [NREAD];
    logic                  rb_port [NREAD];

    for (genvar g = 0; g < NREAD; g++) begin : g_read
        logic [ADDR_WIDTH-1:0] ra;
        logic                  wl_fwd, wa_fwd;

        assign ra     = bus.raddr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wl_fwd = BYPASS && wl_hit_nz && (bus.wl_addr == ra);
        assign wa_fwd = BYPASS && wa_hit_nz && (bus.wa_addr == ra);

        always_comb begin
            if (ra == '0) begin
                rd_port[g] = '0;
            end else if (wl_fwd) begin
                rd_port[g] = bus.wl_data;
            end else if (wa_fwd) begin
                rd_port[g] = bus.wa_data;
            end else begin
                rd_port[g] = rf_q[ra];
            end
            // With forwarding the retiring load value is already on rdata, so it is not busy.
            rb_port[g] = busy_q[ra] && !(BYPASS && bus.wl_en && (bus.wl_addr == ra));
        end
    end

    always_comb begin
        bus.rdata = '0;
        bus.rbusy = '0;
        for (int unsigned i = 0; i < NREAD; i++) begin
            bus.rdata[i*DATA_WIDTH +: DATA_WIDTH] = rd_port[i];
            bus.rbusy[i]                          = rb_port[i];
        end
    end

    assign bus.busy_cnt = busy_cnt;
    assign bus.sb_err   = sb_err_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios plus random traffic checked against
// an array-based model of the register file and its load scoreboard.
module tb_regfile_scoreboard;
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;
    localparam int unsigned NR   = 2;
    localparam int unsigned NREG = 32;
    localparam logic [DW-1:0] SP = 32'h81000000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    logic [DW-1:0] m_rf   [NREG];
    bit            m_busy [NREG];
    bit            m_err;

    always #5 clk = ~clk;

    regfile_scoreboard_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREAD(NR)) bus ();

    regfile_scoreboard #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREAD(NR), .SP_RESET(SP), .BYPASS(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic idle();
        bus.wa_en = 0; bus.wa_addr = '0; bus.wa_data = '0;
        bus.wl_en = 0; bus.wl_addr = '0; bus.wl_data = '0;
        bus.sb_set = 0; bus.sb_addr = '0;
    endtask

    task automatic set_raddr(input int p, input logic [AW-1:0] a);
        bus.raddr[p*AW +: AW] = a;
    endtask

    // Model of one clock edge, applied from the inputs currently on the bus.
    task automatic apply_model();
        int n;
        if (rst) begin
            foreach (m_rf[i]) begin m_rf[i] = '0; m_busy[i] = 0; end
            m_rf[2] = SP;
            m_err   = 0;
        end else begin
            if (bus.wa_en && bus.wa_addr != 0) m_rf[bus.wa_addr] = bus.wa_data;
            if (bus.wl_en && bus.wl_addr != 0) m_rf[bus.wl_addr] = bus.wl_data;
            if (bus.sb_set && bus.sb_addr != 0 && m_busy[bus.sb_addr] &&
                !(bus.wl_en && bus.wl_addr == bus.sb_addr)) m_err = 1;
            if (bus.wl_en) m_busy[bus.wl_addr] = 0;
            if (bus.sb_set && bus.sb_addr != 0) m_busy[bus.sb_addr] = 1;
        end
        n = 0;
    endtask

    task automatic step();
        @(posedge clk);
        apply_model();
        #1;
    endtask

    function automatic int model_cnt();
        int n = 0;
        foreach (m_busy[i]) n += m_busy[i];
        return n;
    endfunction

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (bus.wl_en && bus.wl_addr == a) return bus.wl_data;
        if (bus.wa_en && bus.wa_addr == a) return bus.wa_data;
        return m_rf[a];
    endfunction

    task automatic test_reset();
        idle(); rst = 1; step(); rst = 0;
        set_raddr(0, 5'd2); set_raddr(1, 5'd5); #1;
        total++; if (bus.rdata[0 +: DW] !== SP) begin bad++;
            $display("FAIL reset_sp got=%h exp=%h", bus.rdata[0 +: DW], SP); end
        total++; if (bus.rdata[DW +: DW] !== 32'h0) begin bad++;
            $display("FAIL reset_r5 got=%h exp=0", bus.rdata[DW +: DW]); end
        total++; if (bus.rbusy !== 2'b00) begin bad++;
            $display("FAIL reset_rbusy got=%b exp=00", bus.rbusy); end
        total++; if (bus.busy_cnt !== 6'd0) begin bad++;
            $display("FAIL reset_cnt got=%0d exp=0", bus.busy_cnt); end
        total++; if (bus.sb_err !== 1'b0) begin bad++;
            $display("FAIL reset_err got=%b exp=0", bus.sb_err); end
    endtask

    task automatic test_reg0_and_bypass();
        idle(); bus.wa_en = 1; bus.wa_addr = 0; bus.wa_data = 32'hDEAD; step();
        idle(); set_raddr(0, 0); #1;
        total++; if (bus.rdata[0 +: DW] !== 32'h0) begin bad++;
            $display("FAIL r0_write got=%h exp=0", bus.rdata[0 +: DW]); end
        bus.wa_en = 1; bus.wa_addr = 7; bus.wa_data = 32'h1234; set_raddr(1, 7); #1;
        total++; if (bus.rdata[DW +: DW] !== 32'h1234) begin bad++;
            $display("FAIL wa_bypass got=%h exp=1234", bus.rdata[DW +: DW]); end
        step(); idle(); #1;
        total++; if (bus.rdata[DW +: DW] !== 32'h1234) begin bad++;
            $display("FAIL wa_stored got=%h exp=1234", bus.rdata[DW +: DW]); end
    endtask

    task automatic test_lsu_wins();
        idle(); bus.wa_en = 1; bus.wa_addr = 9; bus.wa_data = 32'h11;
        bus.wl_en = 1; bus.wl_addr = 9; bus.wl_data = 32'h22; set_raddr(0, 9); #1;
        total++; if (bus.rdata[0 +: DW] !== 32'h22) begin bad++;
            $display("FAIL lsu_wins_bypass got=%h exp=22", bus.rdata[0 +: DW]); end
        step(); idle(); #1;
        total++; if (bus.rdata[0 +: DW] !== 32'h22) begin bad++;
            $display("FAIL lsu_wins_stored got=%h exp=22", bus.rdata[0 +: DW]); end
    endtask

    task automatic test_scoreboard();
        idle(); bus.sb_set = 1; bus.sb_addr = 5; step();
        idle(); set_raddr(1, 5); #1;
        total++; if (bus.rbusy[1] !== 1'b1) begin bad++;
            $display("FAIL sb_rbusy got=%b exp=1", bus.rbusy[1]); end
        total++; if (bus.busy_cnt !== 6'd1) begin bad++;
            $display("FAIL sb_cnt got=%0d exp=1", bus.busy_cnt); end
        bus.wl_en = 1; bus.wl_addr = 5; bus.wl_data = 32'hABCD; #1;
        total++; if (bus.rbusy[1] !== 1'b0) begin bad++;
            $display("FAIL wl_rbusy got=%b exp=0", bus.rbusy[1]); end
        total++; if (bus.rdata[DW +: DW] !== 32'hABCD) begin bad++;
            $display("FAIL wl_bypass got=%h exp=abcd", bus.rdata[DW +: DW]); end
        step(); idle(); #1;
        total++; if (bus.busy_cnt !== 6'd0) begin bad++;
            $display("FAIL wl_cnt got=%0d exp=0", bus.busy_cnt); end
    endtask

    task automatic test_sb_err();
        idle(); bus.sb_set = 1; bus.sb_addr = 5; step(); step();
        idle(); #1;
        total++; if (bus.sb_err !== 1'b1) begin bad++;
            $display("FAIL sb_err_set got=%b exp=1", bus.sb_err); end
        step(); step(); #1;
        total++; if (bus.sb_err !== 1'b1) begin bad++;
            $display("FAIL sb_err_hold got=%b exp=1", bus.sb_err); end
        bus.sb_set = 1; bus.sb_addr = 6; bus.wl_en = 1; bus.wl_addr = 5; bus.wl_data = 1;
        step(); idle(); set_raddr(0, 6); set_raddr(1, 5); #1;
        total++; if (bus.busy_cnt !== 6'd1) begin bad++;
            $display("FAIL swap_cnt got=%0d exp=1", bus.busy_cnt); end
        total++; if (bus.rbusy !== 2'b01) begin bad++;
            $display("FAIL swap_rbusy got=%b exp=01", bus.rbusy); end
    endtask

    task automatic test_random();
        idle(); rst = 1; step(); rst = 0;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            bus.wa_en = $urandom_range(0, 1); bus.wa_addr = AW'($urandom_range(0, 7));
            bus.wa_data = $urandom;
            bus.wl_en = ($urandom_range(0, 2) == 0); bus.wl_addr = AW'($urandom_range(0, 7));
            bus.wl_data = $urandom;
            bus.sb_set = ($urandom_range(0, 2) == 0);
            bus.sb_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            for (int p = 0; p < NR; p++) set_raddr(p, AW'($urandom_range(0, 9)));
            #1;
            for (int p = 0; p < NR; p++) begin
                logic [AW-1:0] a;
                logic          eb;
                a  = bus.raddr[p*AW +: AW];
                eb = m_busy[a] && !(bus.wl_en && bus.wl_addr == a);
                total++; if (bus.rdata[p*DW +: DW] !== model_read(a)) begin bad++;
                    $display("FAIL rnd_rdata c=%0d p=%0d a=%0d got=%h exp=%h",
                             c, p, a, bus.rdata[p*DW +: DW], model_read(a)); end
                total++; if (bus.rbusy[p] !== eb) begin bad++;
                    $display("FAIL rnd_rbusy c=%0d p=%0d got=%b exp=%b", c, p, bus.rbusy[p], eb); end
            end
            total++; if (int'(bus.busy_cnt) != model_cnt()) begin bad++;
                $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, bus.busy_cnt, model_cnt()); end
            total++; if (bus.sb_err !== m_err) begin bad++;
                $display("FAIL rnd_err c=%0d got=%b exp=%b", c, bus.sb_err, m_err); end
            step();
        end
        rst = 0;
    endtask

    task automatic test_reset_mid_load();
        idle(); bus.wa_en = 1; bus.wa_addr = 3; bus.wa_data = 32'h77; step();
        idle(); bus.sb_set = 1; bus.sb_addr = 3; step();
        idle(); rst = 1; bus.wl_en = 1; bus.wl_addr = 3; bus.wl_data = 32'h55; step();
        rst = 0; idle(); set_raddr(0, 3); set_raddr(1, 2); #1;
        total++; if (bus.rbusy[0] !== 1'b0) begin bad++;
            $display("FAIL rst_load_rbusy got=%b exp=0", bus.rbusy[0]); end
        total++; if (bus.busy_cnt !== 6'd0) begin bad++;
            $display("FAIL rst_load_cnt got=%0d exp=0", bus.busy_cnt); end
        total++; if (bus.rdata[0 +: DW] !== 32'h0) begin bad++;
            $display("FAIL rst_load_r3 got=%h exp=0", bus.rdata[0 +: DW]); end
        total++; if (bus.rdata[DW +: DW] !== SP) begin bad++;
            $display("FAIL rst_load_sp got=%h exp=%h", bus.rdata[DW +: DW], SP); end
    endtask

    initial begin
        idle();
        bus.raddr = '0;
        foreach (m_rf[i]) begin m_rf[i] = '0; m_busy[i] = 0; end
        m_err = 0;
        @(negedge clk);
        test_reset();
        test_reg0_and_bypass();
        test_lsu_wins();
        test_scoreboard();
        test_sb_err();
        test_random();
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
